// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: scalar, vector and data-memory signals of the shared memory port
interface dmem_arbiter_if #(parameter int N = 24);
    logic         s_req, s_we, s_gnt, s_rvalid;
    logic [N-1:0] s_addr, s_wdata, s_rdata;
    logic         v_req, v_we, v_gnt, v_rvalid, v_done;
    logic [2:0]   v_len;
    logic [N-1:0] v_addr, v_wdata, v_rdata;
    logic         mem_we;
    logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
    modport master (
        output s_req, s_we, s_addr, s_wdata, v_req, v_we, v_addr, v_len, v_wdata, mem_rdata,
        input  s_gnt, s_rvalid, s_rdata, v_gnt, v_rvalid, v_rdata, v_done, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  s_req, s_we, s_addr, s_wdata, v_req, v_we, v_addr, v_len, v_wdata, mem_rdata,
        output s_gnt, s_rvalid, s_rdata, v_gnt, v_rvalid, v_rdata, v_done, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one data-memory port between scalar accesses and vector bursts
module dmem_arbiter #(
    parameter int N         = 24,
    parameter int MAX_BURST = 4
) (
    input logic         clk,
    input logic         rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SGRANT, VGRANT} state_t;
    state_t       state, state_nxt;
    logic         last_v, dir, s_pick, v_pick, last_beat;
    logic [N-1:0] base;
    logic [2:0]   len, beat, len_in;
    always_comb begin
        s_pick        = bus.s_req && (!bus.v_req || last_v);
        v_pick        = bus.v_req && !s_pick;
        len_in        = bus.v_len == 3'd0 ? 3'd1 : bus.v_len > 3'(MAX_BURST) ? 3'(MAX_BURST) : bus.v_len;
        last_beat     = beat == len - 3'd1;
        state_nxt     = state == IDLE ? (s_pick ? SGRANT : v_pick ? VGRANT : IDLE)
                      : (state == VGRANT && !last_beat) ? VGRANT : IDLE;
        bus.s_gnt     = state == SGRANT && bus.s_req;
        bus.v_gnt     = state == VGRANT;
        bus.mem_addr  = bus.s_gnt ? bus.s_addr : bus.v_gnt ? base + N'({beat, 2'b00}) : '0;
        bus.mem_we    = bus.s_gnt ? bus.s_we : bus.v_gnt && dir;
        bus.mem_wdata = bus.s_gnt ? bus.s_wdata : bus.v_gnt ? bus.v_wdata : '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end
    // last_v resets high so the scalar side wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_v       <= 1'b1;
            dir          <= 1'b0;
            base         <= '0;
            len          <= '0;
            beat         <= '0;
            bus.s_rvalid <= 1'b0;
            bus.s_rdata  <= '0;
            bus.v_rvalid <= 1'b0;
            bus.v_rdata  <= '0;
            bus.v_done   <= 1'b0;
        end else begin
            if (state == IDLE && v_pick) begin
                base <= bus.v_addr;
                dir  <= bus.v_we;
                len  <= len_in;
            end
            beat <= bus.v_gnt && !last_beat ? beat + 3'd1 : 3'd0;
            if (bus.s_gnt) last_v <= 1'b0;
            else if (bus.v_gnt && last_beat) last_v <= 1'b1;
            bus.s_rvalid <= bus.s_gnt && !bus.s_we;
            if (bus.s_gnt && !bus.s_we) bus.s_rdata <= bus.mem_rdata;
            bus.v_rvalid <= bus.v_gnt && !dir;
            if (bus.v_gnt && !dir) bus.v_rdata <= bus.mem_rdata;
            bus.v_done <= bus.v_gnt && last_beat;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench with per-requester expected-access queues and a negedge monitor
module tb_dmem_arbiter;
    localparam int N  = 24;
    localparam int MB = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    dmem_arbiter_if #(.N(N)) bus ();
    dmem_arbiter #(.N(N), .MAX_BURST(MB)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic         we;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
        logic         last;
    } acc_t;
    acc_t         s_q[$], v_q[$];
    int           glog[$];
    logic [N-1:0] mem [256];
    logic [N-1:0] ref_mem [256];
    int           vectors = 0, errors = 0;
    logic         mon_en = 1'b0, prev_v = 1'b0;
    logic         exp_srv = 1'b0, exp_vrv = 1'b0, exp_vdone = 1'b0;
    logic [N-1:0] exp_sdata = '0, exp_vdata = '0;

    always_comb bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        acc_t e;
        chk("s_rvalid", bus.s_rvalid, exp_srv);
        if (exp_srv) chk("s_rdata", bus.s_rdata, exp_sdata);
        chk("v_rvalid", bus.v_rvalid, exp_vrv);
        if (exp_vrv) chk("v_rdata", bus.v_rdata, exp_vdata);
        chk("v_done", bus.v_done, exp_vdone);
        chk("gnt_excl", bus.s_gnt & bus.v_gnt, 0);
        chk("we_outside_gnt", bus.mem_we & ~(bus.s_gnt | bus.v_gnt), 0);
        exp_srv = 1'b0;
        exp_vrv = 1'b0;
        exp_vdone = 1'b0;
        if (bus.s_gnt) begin
            glog.push_back(0);
            if (s_q.size() == 0) chk("s_gnt_unexpected", bus.s_gnt, 0);
            else begin
                e = s_q.pop_front();
                chk("s_mem_addr", bus.mem_addr, e.addr);
                chk("s_mem_we", bus.mem_we, e.we);
                if (e.we) begin
                    chk("s_mem_wdata", bus.mem_wdata, e.wdata);
                    ref_mem[e.addr[9:2]] = e.wdata;
                end else begin
                    exp_srv = 1'b1;
                    exp_sdata = ref_mem[e.addr[9:2]];
                end
            end
        end
        if (bus.v_gnt) begin
            if (!prev_v) glog.push_back(1);
            if (v_q.size() == 0) chk("v_gnt_unexpected", bus.v_gnt, 0);
            else begin
                e = v_q.pop_front();
                chk("v_mem_addr", bus.mem_addr, e.addr);
                chk("v_mem_we", bus.mem_we, e.we);
                if (e.we) begin
                    chk("v_mem_wdata", bus.mem_wdata, e.wdata);
                    ref_mem[e.addr[9:2]] = e.wdata;
                end else begin
                    exp_vrv = 1'b1;
                    exp_vdata = ref_mem[e.addr[9:2]];
                end
                exp_vdone = e.last;
            end
        end
        prev_v = bus.v_gnt;
    end

    task automatic s_access(input logic we, input logic [N-1:0] a, input logic [N-1:0] d, output int w);
        acc_t e;
        e.we = we; e.addr = a; e.wdata = d; e.last = 1'b0;
        s_q.push_back(e);
        @(posedge clk); #1;
        bus.s_req = 1'b1; bus.s_we = we; bus.s_addr = a; bus.s_wdata = d;
        w = 0;
        do begin @(negedge clk); w++; end while (!bus.s_gnt && w < 60);
        chk("s_gnt_seen", bus.s_gnt, 1);
        chk("s_wait_bound", w <= MB + 3, 1);
    endtask

    task automatic s_release();
        @(posedge clk); #1;
        bus.s_req = 1'b0;
    endtask

    task automatic v_burst(input logic we, input logic [N-1:0] a, input logic [2:0] len);
        int n = len == 0 ? 1 : (len > MB ? MB : int'(len));
        logic [N-1:0] wd [8];
        acc_t e;
        int w;
        for (int i = 0; i < n; i++) begin
            wd[i] = N'($urandom);
            e.we = we; e.addr = a + N'(4 * i); e.wdata = wd[i]; e.last = (i == n - 1);
            v_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.v_req = 1'b1; bus.v_we = we; bus.v_addr = a; bus.v_len = len; bus.v_wdata = wd[0];
        for (int i = 0; i < n; i++) begin
            w = 0;
            do begin @(negedge clk); w++; end while (!bus.v_gnt && w < 60);
            chk("v_gnt_seen", bus.v_gnt, 1);
            if (i > 0) chk("v_no_bubble", w, 1);
            @(posedge clk); #1;
            bus.v_req = 1'b0;
            if (i + 1 < n) bus.v_wdata = wd[i + 1];
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        mon_en = 1'b0;
        rst = 1'b0;
        s_q.delete(); v_q.delete(); glog.delete();
        exp_srv = 1'b0; exp_vrv = 1'b0; exp_vdone = 1'b0; prev_v = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        acc_t e;
        bus.s_req = 0; bus.s_we = 0; bus.s_addr = '0; bus.s_wdata = '0;
        bus.v_req = 0; bus.v_we = 0; bus.v_addr = '0; bus.v_len = '0; bus.v_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = N'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[8] = 24'h123456;
        ref_mem[8] = 24'h123456;
        repeat (2) @(negedge clk);
        chk("rst_s_gnt", bus.s_gnt, 0);
        chk("rst_v_gnt", bus.v_gnt, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_s_rvalid", bus.s_rvalid, 0);
        chk("rst_v_rvalid", bus.v_rvalid, 0);
        chk("rst_v_done", bus.v_done, 0);
        chk("rst_s_rdata", bus.s_rdata, 0);
        chk("rst_v_rdata", bus.v_rdata, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        mon_en = 1'b1;

        s_access(1'b1, 24'h000010, 24'h00ABCD, w);
        chk("s_write_latency", w, 2);
        s_release();
        s_access(1'b0, 24'h000020, 24'h0, w);
        chk("s_read_latency", w, 2);
        s_release();
        v_burst(1'b0, 24'h000100, 3'd4);
        v_burst(1'b1, 24'h000140, 3'd0);
        v_burst(1'b0, 24'h000180, 3'd7);
        v_burst(1'b1, 24'hFFFFFC, 3'd2);
        v_burst(1'b0, 24'hFFFFFC, 3'd2);
        repeat (3) @(posedge clk);

        do_reset();
        fork
            begin
                for (int i = 0; i < 4; i++) s_access(i[0], N'($urandom), N'($urandom), w);
                s_release();
            end
            for (int i = 0; i < 3; i++) v_burst(1'b0, N'($urandom), 3'd2);
        join
        repeat (3) @(posedge clk);
        chk("order_len", glog.size(), 7);
        for (int i = 0; i < glog.size(); i++) chk("order", glog[i], i % 2);

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    s_access(1'($urandom), N'($urandom), N'($urandom), w);
                    if ($urandom_range(1) == 1) begin
                        s_release();
                        repeat ($urandom_range(3)) @(posedge clk);
                    end
                end
                s_release();
            end
            for (int i = 0; i < 20; i++) begin
                v_burst(1'($urandom), N'($urandom), 3'($urandom));
                repeat ($urandom_range(3)) @(posedge clk);
            end
        join
        repeat (3) @(posedge clk);
        chk("s_q_drained", s_q.size(), 0);
        chk("v_q_drained", v_q.size(), 0);

        do_reset();
        for (int i = 0; i < 2; i++) begin
            e.we = 1'b1; e.addr = 24'h000200 + N'(4 * i); e.wdata = 24'h0A0000 + N'(i); e.last = 1'b0;
            v_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.v_req = 1'b1; bus.v_we = 1'b1; bus.v_addr = 24'h000200; bus.v_len = 3'd4; bus.v_wdata = 24'h0A0000;
        w = 0;
        do begin @(negedge clk); w++; end while (!bus.v_gnt && w < 60);
        chk("mid_v_gnt", bus.v_gnt, 1);
        @(posedge clk); #1;
        bus.v_req = 1'b0; bus.v_wdata = 24'h0A0001;
        bus.s_req = 1'b1; bus.s_we = 1'b0; bus.s_addr = 24'h000040;
        @(negedge clk); #1;
        chk("mid_beat2_we", bus.mem_we, 1);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_mem_we", bus.mem_we, 0);
        chk("async_v_gnt", bus.v_gnt, 0);
        chk("async_mem_addr", bus.mem_addr, 0);
        s_q.delete(); v_q.delete();
        exp_srv = 1'b0; exp_vrv = 1'b0; exp_vdone = 1'b0; prev_v = 1'b0;
        @(posedge clk); #2;
        e.we = 1'b0; e.addr = 24'h000040; e.wdata = '0; e.last = 1'b0;
        s_q.push_back(e);
        rst = 1'b1;
        mon_en = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!bus.s_gnt && w < 60);
        chk("post_rst_s_latency", w, 2);
        s_release();
        repeat (6) @(posedge clk);
        chk("post_rst_v_q", v_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the processor's single data-memory port between two requesters.
- Requester S is the scalar core load/store path.
- Requester V is the vector load/store unit, which issues fixed-stride bursts.
- One memory access per cycle, arbitrated round-robin between S and V.
- Sits between both requesters and the data memory (the A/WD/RD/MemWrite port). The memory read path is combinational.

Parameters:
- N, 24, data and address width.
- MAX_BURST, 4, maximum vector beats per grant. Legal range 1..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- s_req  in  1  scalar access request. Held until s_gnt.
- s_we  in  1  scalar write enable.
- s_addr  in  N  scalar byte address.
- s_wdata  in  N  scalar write data.
- s_gnt  out  1  scalar access performed this cycle.
- s_rvalid  out  1  scalar read data valid (one-cycle pulse).
- s_rdata  out  N  scalar read data.
- v_req  in  1  vector burst request. Held until first v_gnt.
- v_we  in  1  vector burst is write.
- v_addr  in  N  vector burst base byte address.
- v_len  in  3  beat count.
- v_wdata  in  N  write data for current beat. Next word is presented after each v_gnt.
- v_gnt  out  1  vector beat performed this cycle.
- v_rvalid  out  1  vector read beat valid.
- v_rdata  out  N  vector read data.
- v_done  out  1  one-cycle pulse: burst complete.
- mem_addr  out  N  to data memory A.
- mem_we  out  1  to data memory MemWrite.
- mem_wdata  out  N  to data memory WD.
- mem_rdata  in  N  from data memory RD, combinational.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, beat counter=0, last_served=V (S wins the first tie).
  - All outputs 0. Any burst in progress is aborted and v_done is not asserted for it.
- FSM states: IDLE, SGRANT, VGRANT.
- IDLE:
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - Only s_req high -> SGRANT. Only v_req high -> VGRANT.
  - Both high -> the requester not equal to last_served. Neither -> stay IDLE.
- Entry to VGRANT latches:
  - base=v_addr, dir=v_we.
  - len = 1 if v_len=0; MAX_BURST if v_len>MAX_BURST; else v_len.
  - beat=0.
- SGRANT (one cycle):
  - If s_req still 1: drive mem_addr=s_addr, mem_we=s_we, mem_wdata=s_wdata; s_gnt=1 (combinational); last_served<=S.
  - If s_req dropped: no access, mem_we=0.
  - Always -> IDLE.
- VGRANT (len cycles, one beat each, no bubbles):
  - mem_addr = base + 4*beat, modulo 2^N (wraps).
  - mem_we=dir, mem_wdata=v_wdata, v_gnt=1.
  - v_req is ignored after entry.
  - On the last beat: last_served<=V, then -> IDLE.
- Read return:
  - On any granted read, mem_rdata is registered at the clock edge ending the grant cycle.
  - Next cycle: s_rvalid/s_rdata or v_rvalid/v_rdata = captured value. Latency 1 cycle after gnt.
  - Writes produce no rvalid.
- v_done:
  - Pulses in the cycle after the last beat's grant, for both read and write bursts.
  - Coincides with the last v_rvalid for reads.
- s_rdata and v_rdata hold their last value when rvalid=0.
- Throughput and fairness:
  - A scalar access costs 2 cycles from request (IDLE decision + SGRANT).
  - Worst-case scalar wait is MAX_BURST+2 cycles.
  - With both requesting continuously, grants alternate S, V, S, V...
- mem_we never asserts outside SGRANT/VGRANT. s_gnt and v_gnt are never high together.

Test Plan:
- Scalar write: s_req=1, s_we=1, s_addr=0x000010, s_wdata=0x00ABCD -> 2nd cycle: mem_we=1, mem_addr=0x000010, mem_wdata=0x00ABCD, s_gnt=1 for exactly one cycle; s_rvalid never asserts.
- Scalar read: s_we=0, s_addr=0x000020, memory returns 0x123456 -> s_gnt cycle followed by s_rvalid=1, s_rdata=0x123456 for one cycle.
- Vector read burst: v_addr=0x000100, v_len=4 -> mem_addr 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles, v_gnt high 4 cycles; v_rvalid 4 cycles lagging by 1; v_done on the cycle of the 4th v_rvalid.
- Both requesting continuously from reset (v_len=2) -> order S, V(2 beats), S, V...; s_gnt/v_gnt never overlap.
- Clamping and wrap:
  - v_len=0 -> exactly 1 beat.
  - v_len=7 with MAX_BURST=4 -> 4 beats.
  - v_addr=0xFFFFFC, v_len=2 -> mem_addr 0xFFFFFC then 0x000000.
- Reset mid-burst: vector write v_len=4, rst=0 during beat 2 -> mem_we=0 immediately (async); after release state=IDLE, no v_done; a pending s_req is granted next.
